// File: rtl/insfetch_q_pkg.sv
// insfetch_q_pkg: shared opcodes, HALT word, fetch state encoding and RVC constants.
package insfetch_q_pkg;
  localparam logic [6:0]  OJAL     = 7'b1101111;
  localparam logic [6:0]  OJALR    = 7'b1100111;
  localparam logic [31:0] HALT_INS = 32'h0ff00513;
  localparam logic [1:0]  C_OP_J   = 2'b01;
  localparam logic [2:0]  C_F3_J   = 3'b101;
  localparam logic [1:0]  C_OP_JR  = 2'b10;
  localparam logic [2:0]  C_F3_JR  = 3'b100;
  typedef enum logic [1:0] {S_FETCH, S_WAIT_JALR, S_HALTED} fstate_t;
endpackage

// File: rtl/insfetch_q_fetch_queue.sv
// fetch_queue: circular instruction buffer with a registered head so decode never sees give_you combinationally.
module fetch_queue #(
  parameter int QDEPTH = 8,
  parameter int WIDTH  = 65
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq,
  input  logic                       deq,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(QDEPTH):0]    count,
  output logic [WIDTH-1:0]           head
);
  localparam int PW = $clog2(QDEPTH);
  logic [WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0] hp, tp, hn;
  logic [PW:0] cn;
  logic do_enq, do_deq;
  assign full   = count == (PW+1)'(QDEPTH);
  assign empty  = count == '0;
  assign do_enq = enq && !full && !flush;
  assign do_deq = deq && !empty && !flush;
  assign hn     = hp + PW'(do_deq);
  assign cn     = count + (PW+1)'(do_enq) - (PW+1)'(do_deq);
  // head is refreshed from the entry that becomes oldest; bypass din when it lands in an otherwise empty queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hp    <= '0;
      tp    <= '0;
      count <= '0;
      head  <= '0;
    end else if (flush) begin
      hp    <= '0;
      tp    <= '0;
      count <= '0;
    end else begin
      hp    <= hn;
      tp    <= tp + PW'(do_enq);
      count <= cn;
      if (cn != '0) head <= (count == (PW+1)'(do_deq)) ? din : mem[hn];
    end
  end
  always_ff @(posedge clk) begin
    if (do_enq) mem[tp] <= din;
  end
endmodule

// File: rtl/insfetch_q.sv
// insfetch_q: fetch PC/state machine feeding a fetch_queue; optional compressed decode under RVC_EN.
module insfetch_q
  import insfetch_q_pkg::*;
#(
  parameter int              QDEPTH   = 8,
  parameter int              ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic [ADDR_W-1:0] out_PC,
  output logic              ask_for,
  input  logic              give_you,
  input  logic [31:0]       give_you_ins,
  output logic              is_ins,
  output logic [ADDR_W-1:0] ins_addr,
  output logic [31:0]       ins,
  output logic              ins_is_c,
  input  logic              rob_rs_slb_full,
  input  logic              rob_clear,
  input  logic [ADDR_W-1:0] rob_new_pc,
  input  logic              cancel_stuck
);
  localparam int WIDTH = ADDR_W + 33;
  fstate_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, jimm, cimm, len;
  logic [31:0] w, word;
  logic [$clog2(QDEPTH):0] count;
  logic [WIDTH-1:0] head;
  logic full, empty, accept, deq, is_c, is_cj, is_cjr, is_jal, is_jalr, is_halt;
  assign w = give_you_ins;
`ifdef RVC_EN
  assign is_c   = w[1:0] != 2'b11;
  assign is_cj  = w[1:0] == C_OP_J && w[15:13] == C_F3_J;
  assign is_cjr = w[1:0] == C_OP_JR && w[15:13] == C_F3_JR && w[11:7] != '0 && w[6:2] == '0;
  assign word   = is_c ? {16'b0, w[15:0]} : w;
`else
  assign is_c   = 1'b0;
  assign is_cj  = 1'b0;
  assign is_cjr = 1'b0;
  assign word   = w;
`endif
  assign is_halt = !is_c && w == HALT_INS;
  assign is_jalr = is_c ? is_cjr : w[6:0] == OJALR;
  assign is_jal  = !is_c && w[6:0] == OJAL;
  assign jimm    = {{(ADDR_W-20){w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  assign cimm    = {{(ADDR_W-11){w[12]}}, w[8], w[10:9], w[6], w[7], w[2], w[11], w[5:3], 1'b0};
  assign len     = is_c ? ADDR_W'(2) : ADDR_W'(4);
  assign out_PC  = pc;
  assign ask_for = state == S_FETCH && !full;
  assign accept  = rdy_in && !rob_clear && ask_for && give_you;
  assign deq     = rdy_in && !rob_clear && !empty && !rob_rs_slb_full;
  assign is_ins  = count != '0;
  assign ins_addr = head[WIDTH-1:33];
  assign ins      = head[32:1];
  assign ins_is_c = head[0];
  fetch_queue #(.QDEPTH(QDEPTH), .WIDTH(WIDTH)) u_q (
    .clk   (clk_in),
    .rst   (rst_in),
    .enq   (accept),
    .deq   (deq),
    .flush (rdy_in && rob_clear),
    .din   ({pc, word, is_c}),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (head)
  );
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
    end else if (rdy_in) begin
      state <= state_n;
      pc    <= pc_n;
    end
  end
  // rob_clear outranks everything; JALR and HALT park the PC on the fetched instruction
  always_comb begin
    state_n = state;
    pc_n    = pc;
    if (rob_clear) begin
      state_n = S_FETCH;
      pc_n    = rob_new_pc;
    end else if (accept) begin
      state_n = is_halt ? S_HALTED : is_jalr ? S_WAIT_JALR : S_FETCH;
      pc_n    = (is_halt || is_jalr) ? pc : is_jal ? pc + jimm : is_cj ? pc + cimm : pc + len;
    end else if (state == S_WAIT_JALR && cancel_stuck) begin
      state_n = S_FETCH;
      pc_n    = rob_new_pc;
    end
  end
endmodule

// File: tb/tb_insfetch_q.sv
// tb_insfetch_q: scoreboard bench for insfetch_q; covers the RVC_EN path when that macro is defined.
module tb_insfetch_q;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] JAL  = 32'h0100006f;
  localparam logic [31:0] JALR = 32'h00008067;
  localparam logic [31:0] HALT = 32'h0ff00513;
  logic clk_in = 0, rst_in = 1, rdy_in = 1, give_you = 0, rob_rs_slb_full = 0, rob_clear = 0, cancel_stuck = 0;
  logic [31:0] give_you_ins = 0, rob_new_pc = 0, out_PC, ins_addr, ins;
  logic ask_for, is_ins, ins_is_c;
  logic [31:0] mpc = 0;
  logic [63:0] sb[$];
  int nvec = 0, nerr = 0;
  always #5 clk_in = ~clk_in;
  insfetch_q dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .out_PC(out_PC), .ask_for(ask_for),
    .give_you(give_you), .give_you_ins(give_you_ins), .is_ins(is_ins), .ins_addr(ins_addr),
    .ins(ins), .ins_is_c(ins_is_c), .rob_rs_slb_full(rob_rs_slb_full), .rob_clear(rob_clear),
    .rob_new_pc(rob_new_pc), .cancel_stuck(cancel_stuck)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask
  // check one cycle at the negedge, update the scoreboard, then advance to the next negedge
  task automatic tick(input bit acc, input logic [31:0] npc);
    logic [63:0] e;
    chk("pc", 64'(out_PC), 64'(mpc));
    chk("is_ins", 64'(is_ins), 64'(sb.size() != 0));
    if (give_you && !rob_clear) chk("ask_for", 64'(ask_for), 64'(acc));
    if (rdy_in && !rob_clear && sb.size() != 0 && !rob_rs_slb_full) begin
      e = sb.pop_front();
      chk("ins_addr", 64'(ins_addr), 64'(e[63:32]));
      chk("ins", 64'(ins), 64'(e[31:0]));
    end
    if (rdy_in && !rob_clear && acc && give_you) sb.push_back({mpc, give_you_ins});
    if (rdy_in && rob_clear) sb.delete();
    @(posedge clk_in);
    @(negedge clk_in);
    mpc = npc;
  endtask
  initial begin
    repeat (2) @(negedge clk_in);
    rst_in = 0;
    chk("rst_is_ins", 64'(is_ins), 0);
    chk("rst_ins", 64'(ins), 0);
    chk("rst_ins_addr", 64'(ins_addr), 0);
    chk("rst_ins_is_c", 64'(ins_is_c), 0);
    chk("rst_ask_for", 64'(ask_for), 1);
    rob_rs_slb_full = 1; give_you = 1; give_you_ins = ADDI;
    for (int i = 0; i < 8; i++) tick(1, mpc + 4);
    chk("full_pc", 64'(out_PC), 64'h20);
    tick(0, mpc);
    rob_rs_slb_full = 0; rdy_in = 0;
    tick(0, mpc);
    rdy_in = 1; give_you = 0;
    for (int i = 0; i < 8; i++) tick(0, mpc);
    rob_clear = 1; rob_new_pc = 32'h10;
    tick(0, 32'h10);
    rob_clear = 0; give_you = 1; give_you_ins = JAL;
    tick(1, 32'h20);
    give_you = 0;
    tick(0, mpc);
    rob_clear = 1; rob_new_pc = 32'h40;
    tick(0, 32'h40);
    rob_clear = 0; give_you = 1; give_you_ins = JALR;
    tick(1, 32'h40);
    tick(0, 32'h40);
    give_you = 0; cancel_stuck = 1; rob_new_pc = 32'h100;
    tick(0, 32'h100);
    cancel_stuck = 0;
    chk("jalr_resume_ask", 64'(ask_for), 1);
    give_you = 1; give_you_ins = HALT;
    tick(1, 32'h100);
    tick(0, 32'h100);
    give_you = 0; cancel_stuck = 1; rob_new_pc = 32'h300;
    tick(0, 32'h100);
    chk("halt_ask", 64'(ask_for), 0);
    cancel_stuck = 0; rob_clear = 1; rob_new_pc = 32'h200;
    tick(0, 32'h200);
    rob_clear = 0;
    chk("halt_exit_ask", 64'(ask_for), 1);
    rob_rs_slb_full = 1; give_you = 1; give_you_ins = ADDI;
    for (int i = 0; i < 5; i++) tick(1, mpc + 4);
    rob_clear = 1; rob_new_pc = 32'h500; rob_rs_slb_full = 0;
    tick(0, 32'h500);
    rob_clear = 0; give_you = 0;
    chk("flush_is_ins", 64'(is_ins), 0);
    chk("flush_hold_addr", 64'(ins_addr), 64'h200);
    give_you = 1;
    tick(1, 32'h504);
    give_you = 0;
    tick(0, mpc);
`ifdef RVC_EN
    rob_clear = 1; rob_new_pc = 0;
    tick(0, 0);
    rob_clear = 0; give_you = 1; give_you_ins = 32'h00004501;
    tick(1, 32'h2);
    chk("rvc_is_c", 64'(ins_is_c), 1);
    give_you_ins = 32'h0000a021;
    tick(1, 32'ha);
    give_you = 0;
    tick(0, mpc);
`endif
    chk("sb_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/insfetch_q.md
Name: insfetch_q

Overview:
- Next-generation instruction fetch unit.
- Owns the architectural fetch PC and requests instruction words from the memory manager.
- Computes the next PC:
  - sequential;
  - JAL target;
  - JALR wait for ROB;
  - HALT.
- Buffers fetched instructions in a parametrised FIFO so decode stalls (ROB/RS/SLB full) do not stall fetch. Sits between the memory manager and the decoder.

Parameters:
- QDEPTH, 8, instruction-queue entries; power of two, >= 2.
- ADDR_W, 32, PC/address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- rdy_in  in  1  global enable; when low, all state holds
- out_PC  out  ADDR_W  current fetch PC presented to memory
- ask_for  out  1  fetch request = (state==FETCH) && (count<QDEPTH)
- give_you  in  1  memory returns the word for out_PC
- give_you_ins  in  32  returned instruction word
- is_ins  out  1  queue head valid (count!=0)
- ins_addr  out  ADDR_W  PC of queue head
- ins  out  32  queue-head instruction word
- ins_is_c  out  1  head is a 16-bit compressed instruction (0 when RVC_EN is undefined)
- rob_rs_slb_full  in  1  decoder backpressure; dequeue = is_ins && !rob_rs_slb_full
- rob_clear  in  1  flush: mispredict or exception
- rob_new_pc  in  ADDR_W  redirect PC for rob_clear and cancel_stuck
- cancel_stuck  in  1  JALR target resolved

Behaviour:
- Reset (async, rst_in=1):
  - PC=RESET_PC, state=FETCH, count=0, head=tail=0.
  - is_ins=0, ins_addr=0, ins=0, ins_is_c=0.
  - Queue contents are don't-care.
- rdy_in=0: no state change, no enqueue or dequeue.
- States:
  - FETCH
  - WAIT_JALR
  - HALTED
- Accept condition: a word is accepted only when give_you && ask_for in the same cycle. A give_you with ask_for low is dropped; PC is unchanged, so memory refetches.
- On accept (FETCH):
  - Enqueue {PC, word, is_c}.
  - Word == 32'h0ff00513: enqueue, state->HALTED, PC holds.
  - Opcode JALR: enqueue, state->WAIT_JALR, PC holds.
  - Opcode JAL: PC <= PC + sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
  - Otherwise: PC <= PC + len, where len=4 (len=2 only under RVC_EN).
  - All PC arithmetic is modulo 2^ADDR_W; wrap is silent.
- WAIT_JALR: cancel_stuck -> PC<=rob_new_pc, state->FETCH; the next fetch starts the following cycle.
- HALTED: cancel_stuck ignored; only rob_clear leaves HALTED.
- rob_clear (highest priority, overrides accept, dequeue and cancel_stuck in that cycle):
  - count=0, head=tail=0.
  - PC<=rob_new_pc, state->FETCH.
  - The give_you word in that cycle is discarded.
- Queue:
  - Circular buffer, log2(QDEPTH)-bit pointers wrapping naturally.
  - count ranges 0..QDEPTH.
  - Simultaneous enqueue+dequeue keeps count constant.
  - Full (count==QDEPTH): ask_for=0, so no enqueue.
  - Empty: is_ins=0; ins/ins_addr hold their last values.
- Latency: an instruction accepted in cycle t is visible at the head (is_ins=1) in cycle t+1 if the queue was empty.
- Outputs ins/ins_addr/ins_is_c are driven from registered queue storage; no combinational path from give_you to the decoder.

Optional Feature:
RVC_EN
- Defined:
  - len=2 when give_you_ins[1:0]!=2'b11; the word is enqueued with its low 16 bits valid and ins_is_c=1.
  - c.j (funct3=101, op=01) is treated like JAL with the CJ-format immediate.
  - c.jr/c.jalr (funct4=100x, op=10, rs1!=0, rs2=0) are treated like JALR (WAIT_JALR).
- Undefined: len always 4; ins_is_c tied 0; no compressed decode logic.

Decomposition:
- Shared package/const file:
  - opcode constants ojal, ojalr;
  - HALT_INS = 32'h0ff00513;
  - fetch state encoding;
  - RVC opcode/funct constants.
- Sub-module fetch_queue (parametrised QDEPTH, WIDTH = ADDR_W+33):
  - enq/deq/flush inputs;
  - full/empty/count outputs;
  - head data output.
- insfetch_q keeps the PC/state machine and next-PC logic.

Test Plan:
- Sequential: reset, memory returns addi words for PC 0,4,8 -> queue holds ins_addr 0,4,8 in order; with rob_rs_slb_full=1, after 8 accepts ask_for=0 and PC=0x20.
- JAL: word 0x0100006f at PC 0x10 -> next out_PC=0x20; entry ins_addr=0x10 enqueued.
- JALR: word 0x00008067 at PC 0x40 -> state WAIT_JALR, ask_for=0; cancel_stuck with rob_new_pc=0x100 -> out_PC=0x100, ask_for=1 next cycle.
- HALT: 0x0ff00513 -> HALTED, cancel_stuck ignored; rob_clear with rob_new_pc=0x200 -> FETCH, PC=0x200.
- Flush race: queue holds 5 entries, rob_clear + give_you + dequeue in the same cycle -> count=0, is_ins=0 next cycle, word dropped, PC=rob_new_pc.
- RVC_EN: word 0x00004501 (c.li) at PC 0x0 -> ins_is_c=1, next PC=0x2; c.j at 0x2 with offset +8 -> PC=0xA.
